// File: rtl/im_sched_pkg.sv
// Shared definitions for the IM scheduler: index widths, link FSM states
// and the one-hot direction check.
package im_sched_pkg;

  localparam logic [0:0] LINK_FREE = 1'b0;
  localparam logic [0:0] LINK_BUSY = 1'b1;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/im_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N-1.
module rr_pick
  import im_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic [N-1:0]         pick,
  output logic                 valid
);

  localparam int PW = idx_w(N);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/im_sched.sv
// Clocked IM scheduler: grants at most one CM link per cycle to a waiting
// input port and holds the crossbar configuration until the link is released.
module im_sched
  import im_sched_pkg::*;
#(
  parameter int MN = 2,
  parameter int NN = 2,
  parameter int SN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NN-1:0]            req,
  input  logic [NN-1:0][SN-1:0]    deci,
  input  logic [MN-1:0][SN-1:0]    cms,
  input  logic [MN-1:0]            rel,
  output logic [MN-1:0][NN-1:0]    cfg,
  output logic [NN-1:0]            gnt,
  output logic [MN-1:0]            busy,
  output logic                     err
);

  localparam int IPW = idx_w(NN);
  localparam int CPW = idx_w(MN);

  logic [MN-1:0][NN-1:0] cfg_q, cfg_d;
  logic                  err_q, err_d;
  logic [IPW-1:0]        ip_ptr_q, ip_ptr_d;
  logic [CPW-1:0]        cm_ptr_q, cm_ptr_d;

  logic [NN-1:0] deci_ok, deci_bad, port_cand, port_oh;
  logic          port_vld;
  logic [MN-1:0] link_st, link_cand, link_oh;
  logic          link_vld;
  logic [IPW-1:0] port_idx;
  logic [CPW-1:0] link_idx;
  logic [SN-1:0]  sel_deci;

  always_comb begin
    gnt = '0;
    for (int m = 0; m < MN; m++) gnt = gnt | cfg_q[m];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_port
      assign deci_ok[gi]   = is_onehot(32'(deci[gi]));
      assign deci_bad[gi]  = req[gi] & (deci[gi] != '0) & ~deci_ok[gi];
      assign port_cand[gi] = req[gi] & ~gnt[gi] & deci_ok[gi];
    end
    // A link released this cycle still reads BUSY, so it is only offered next cycle.
    for (gi = 0; gi < MN; gi++) begin : g_link
      assign busy[gi]      = |cfg_q[gi];
      assign link_st[gi]   = busy[gi] ? LINK_BUSY : LINK_FREE;
      assign link_cand[gi] = port_vld & (link_st[gi] == LINK_FREE) & (|(cms[gi] & sel_deci));
    end
  endgenerate

  rr_pick #(.N(NN)) u_port_pick (
    .req   (port_cand),
    .ptr   (ip_ptr_q),
    .pick  (port_oh),
    .valid (port_vld)
  );

  rr_pick #(.N(MN)) u_link_pick (
    .req   (link_cand),
    .ptr   (cm_ptr_q),
    .pick  (link_oh),
    .valid (link_vld)
  );

  always_comb begin
    port_idx = '0;
    sel_deci = '0;
    for (int i = 0; i < NN; i++) begin
      if (port_oh[i]) begin
        port_idx = IPW'(i);
        sel_deci = deci[i];
      end
    end
    link_idx = '0;
    for (int m = 0; m < MN; m++) begin
      if (link_oh[m]) link_idx = CPW'(m);
    end
  end

  always_comb begin
    cfg_d    = cfg_q;
    ip_ptr_d = ip_ptr_q;
    cm_ptr_d = cm_ptr_q;
    for (int m = 0; m < MN; m++) begin
      if (rel[m]) cfg_d[m] = '0;
      if (link_vld && link_oh[m]) cfg_d[m] = port_oh;
    end
    // The pointer moves past the chosen port even when it found no link.
    if (port_vld) ip_ptr_d = (port_idx == IPW'(NN-1)) ? '0 : port_idx + 1'b1;
    if (link_vld) cm_ptr_d = (link_idx == CPW'(MN-1)) ? '0 : link_idx + 1'b1;
    err_d = err_q | (|(rel & ~busy)) | (|deci_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      err_q    <= 1'b0;
      ip_ptr_q <= '0;
      cm_ptr_q <= '0;
    end else begin
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      ip_ptr_q <= ip_ptr_d;
      cm_ptr_q <= cm_ptr_d;
    end
  end

  assign cfg = cfg_q;
  assign err = err_q;

endmodule
